gate_response_checker: RTL and testbench

//   Synthesizable response analyzer for single-output logic gates.

---
 rtl/gate_response_checker.sv | 167 ++++++++++++++++
 tb/tb_gate_response_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
// Response analyzer for single-output logic gates.
// Each accepted (a, y) pair is compared with the golden gate function.
// The checker counts vectors and mismatches and records the first failure.
module gate_response_checker #(
  parameter int N_IN  = 1,
  parameter int FUNC  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_vec_i,
  input  logic             vec_valid_i,
  input  logic [N_IN-1:0]  vec_a_i,
  input  logic             vec_y_i,
  output logic             vec_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             first_err_vld_o,
  output logic [CNT_W-1:0] first_err_idx_o,
  output logic [N_IN-1:0]  first_err_a_o
);

  // Only the four gate functions are supported; anything else stops elaboration.
  if ((FUNC < 32'sd0) || (FUNC > 32'sd3)) begin : g_bad_func
    $error("gate_response_checker: FUNC must be 0..3");
  end

  localparam logic [1:0]       FUNC_SEL = FUNC[1:0];
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Golden response of the gate under test. NOT looks at a[0] only;
  // the XOR case is the parity of the stimulus.
  function automatic logic golden(input logic [N_IN-1:0] a);
    logic r;
    case (FUNC_SEL)
      2'd0:    r = ~a[0];
      2'd1:    r = &a;
      2'd2:    r = |a;
      2'd3:    r = ^a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             fe_vld_q, fe_vld_d;
  logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
  logic [N_IN-1:0]  fe_a_q, fe_a_d;

  logic accept_s;
  logic mismatch_s;

  assign accept_s   = vec_valid_i && (state_q == ST_RUN);
  assign mismatch_s = (vec_y_i != golden(vec_a_i));

  // State and result registers; reset discards any run in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      num_q     <= CNT_ZERO;
      vec_cnt_q <= CNT_ZERO;
      err_cnt_q <= CNT_ZERO;
      fe_vld_q  <= 1'b0;
      fe_idx_q  <= CNT_ZERO;
      fe_a_q    <= {N_IN{1'b0}};
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
      fe_vld_q  <= fe_vld_d;
      fe_idx_q  <= fe_idx_d;
      fe_a_q    <= fe_a_d;
    end
  end

  // Next-state and result update: start a run, score accepted pairs, finish.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    fe_vld_d  = fe_vld_q;
    fe_idx_d  = fe_idx_q;
    fe_a_d    = fe_a_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          num_d     = num_vec_i;
          vec_cnt_d = CNT_ZERO;
          err_cnt_d = CNT_ZERO;
          fe_vld_d  = 1'b0;
          fe_idx_d  = CNT_ZERO;
          fe_a_d    = {N_IN{1'b0}};
          // An empty run completes immediately as a pass.
          if (num_vec_i != CNT_ZERO) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          vec_cnt_d = vec_cnt_q + CNT_ONE;
          if (mismatch_s) begin
            if (err_cnt_q != CNT_MAX) begin
              err_cnt_d = err_cnt_q + CNT_ONE;
            end else begin
              err_cnt_d = err_cnt_q;
            end
            // Index is the pre-increment count, i.e. 0-based vector number.
            if (!fe_vld_q) begin
              fe_vld_d = 1'b1;
              fe_idx_d = vec_cnt_q;
              fe_a_d   = vec_a_i;
            end else begin
              fe_vld_d = fe_vld_q;
            end
          end else begin
            err_cnt_d = err_cnt_q;
          end
          // The last pair closes the run on the same edge it is accepted.
          if (vec_cnt_d == num_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign vec_ready_o     = (state_q == ST_RUN);
  assign busy_o          = (state_q == ST_RUN);
  assign done_o          = (state_q == ST_DONE);
  assign pass_o          = (state_q == ST_DONE) && (err_cnt_q == CNT_ZERO);
  assign vec_cnt_o       = vec_cnt_q;
  assign err_cnt_o       = err_cnt_q;
  assign first_err_vld_o = fe_vld_q;
  assign first_err_idx_o = fe_idx_q;
  assign first_err_a_o   = fe_a_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: NOT/16-bit, AND2/16-bit and
// NOT/2-bit-counter instances, each checked against hand-computed results.
module tb_gate_response_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // ---------------- instance 0: NOT, N_IN=1, CNT_W=16
  logic        s0_start = 1'b0, s0_valid = 1'b0, s0_y = 1'b0;
  logic [15:0] s0_num = 16'd0;
  logic [0:0]  s0_a = 1'b0;
  logic        o0_ready, o0_busy, o0_done, o0_pass, o0_fev;
  logic [15:0] o0_vcnt, o0_ecnt, o0_fidx;
  logic [0:0]  o0_fa;

  gate_response_checker #(.N_IN(1), .FUNC(0), .CNT_W(16)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s0_start), .num_vec_i(s0_num),
    .vec_valid_i(s0_valid), .vec_a_i(s0_a), .vec_y_i(s0_y),
    .vec_ready_o(o0_ready), .busy_o(o0_busy), .done_o(o0_done), .pass_o(o0_pass),
    .vec_cnt_o(o0_vcnt), .err_cnt_o(o0_ecnt), .first_err_vld_o(o0_fev),
    .first_err_idx_o(o0_fidx), .first_err_a_o(o0_fa));

  // ---------------- instance 1: AND, N_IN=2, CNT_W=16
  logic        s1_start = 1'b0, s1_valid = 1'b0, s1_y = 1'b0;
  logic [15:0] s1_num = 16'd0;
  logic [1:0]  s1_a = 2'd0;
  logic        o1_ready, o1_busy, o1_done, o1_pass, o1_fev;
  logic [15:0] o1_vcnt, o1_ecnt, o1_fidx;
  logic [1:0]  o1_fa;

  gate_response_checker #(.N_IN(2), .FUNC(1), .CNT_W(16)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s1_start), .num_vec_i(s1_num),
    .vec_valid_i(s1_valid), .vec_a_i(s1_a), .vec_y_i(s1_y),
    .vec_ready_o(o1_ready), .busy_o(o1_busy), .done_o(o1_done), .pass_o(o1_pass),
    .vec_cnt_o(o1_vcnt), .err_cnt_o(o1_ecnt), .first_err_vld_o(o1_fev),
    .first_err_idx_o(o1_fidx), .first_err_a_o(o1_fa));

  // ---------------- instance 2: NOT, N_IN=1, CNT_W=2
  logic        s2_start = 1'b0, s2_valid = 1'b0, s2_y = 1'b0;
  logic [1:0]  s2_num = 2'd0;
  logic [0:0]  s2_a = 1'b0;
  logic        o2_ready, o2_busy, o2_done, o2_pass, o2_fev;
  logic [1:0]  o2_vcnt, o2_ecnt, o2_fidx;
  logic [0:0]  o2_fa;

  gate_response_checker #(.N_IN(1), .FUNC(0), .CNT_W(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s2_start), .num_vec_i(s2_num),
    .vec_valid_i(s2_valid), .vec_a_i(s2_a), .vec_y_i(s2_y),
    .vec_ready_o(o2_ready), .busy_o(o2_busy), .done_o(o2_done), .pass_o(o2_pass),
    .vec_cnt_o(o2_vcnt), .err_cnt_o(o2_ecnt), .first_err_vld_o(o2_fev),
    .first_err_idx_o(o2_fidx), .first_err_a_o(o2_fa));

  // Compare one observed value with its expected value and log mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start0(input logic [15:0] n);
    s0_start = 1'b1; s0_num = n; tick(); s0_start = 1'b0;
  endtask

  task automatic send0(input logic a, input logic y);
    s0_valid = 1'b1; s0_a = a; s0_y = y; tick(); s0_valid = 1'b0;
  endtask

  task automatic send2(input logic a, input logic y);
    s2_valid = 1'b1; s2_a = a; s2_y = y; tick(); s2_valid = 1'b0;
  endtask

  initial begin
    // ---- reset state
    tick(); tick();
    check("rst_ready", o0_ready, 32'd0);
    check("rst_busy",  o0_busy,  32'd0);
    check("rst_done",  o0_done,  32'd0);
    check("rst_pass",  o0_pass,  32'd0);
    check("rst_vcnt",  o0_vcnt,  32'd0);
    rst_n = 1'b1;
    tick();

    // ---- 1: NOT, two correct pairs
    start0(16'd2);
    check("t1_ready", o0_ready, 32'd1);
    check("t1_busy",  o0_busy,  32'd1);
    send0(1'b0, 1'b1);
    send0(1'b1, 1'b0);
    check("t1_done",  o0_done,  32'd1);
    check("t1_pass",  o0_pass,  32'd1);
    check("t1_busy0", o0_busy,  32'd0);
    check("t1_rdy0",  o0_ready, 32'd0);
    check("t1_vcnt",  o0_vcnt,  32'd2);
    check("t1_ecnt",  o0_ecnt,  32'd0);
    check("t1_fev",   o0_fev,   32'd0);

    // ---- 2: NOT, two mismatches at indices 1 and 2
    start0(16'd4);
    send0(1'b0, 1'b1);
    send0(1'b1, 1'b1);
    send0(1'b0, 1'b0);
    check("t2_mid_vcnt", o0_vcnt, 32'd3);
    check("t2_mid_busy", o0_busy, 32'd1);
    send0(1'b1, 1'b0);
    check("t2_done", o0_done, 32'd1);
    check("t2_ecnt", o0_ecnt, 32'd2);
    check("t2_fev",  o0_fev,  32'd1);
    check("t2_fidx", o0_fidx, 32'd1);
    check("t2_fa",   o0_fa,   32'd1);
    check("t2_pass", o0_pass, 32'd0);

    // ---- 4a: empty run passes the next cycle and clears old results
    start0(16'd0);
    check("t4_done", o0_done, 32'd1);
    check("t4_pass", o0_pass, 32'd1);
    check("t4_vcnt", o0_vcnt, 32'd0);
    check("t4_ecnt", o0_ecnt, 32'd0);
    check("t4_fev",  o0_fev,  32'd0);

    // ---- 4b: start during RUN is ignored; valid ignored in DONE
    start0(16'd3);
    send0(1'b0, 1'b1);
    s0_start = 1'b1; s0_num = 16'd1; tick(); s0_start = 1'b0;
    check("t4_run_busy", o0_busy, 32'd1);
    check("t4_run_vcnt", o0_vcnt, 32'd1);
    send0(1'b1, 1'b0);
    check("t4_run_busy2", o0_busy, 32'd1);
    send0(1'b1, 1'b0);
    check("t4_done3", o0_done, 32'd1);
    check("t4_vcnt3", o0_vcnt, 32'd3);
    send0(1'b1, 1'b1);
    send0(1'b0, 1'b0);
    check("t4_hold_vcnt", o0_vcnt, 32'd3);
    check("t4_hold_ecnt", o0_ecnt, 32'd0);
    check("t4_hold_pass", o0_pass, 32'd1);

    // ---- 5: async reset mid-run, then restart
    start0(16'd5);
    send0(1'b0, 1'b0);
    send0(1'b1, 1'b0);
    check("t5_pre_ecnt", o0_ecnt, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy",  o0_busy,  32'd0);
    check("t5_ready", o0_ready, 32'd0);
    check("t5_done",  o0_done,  32'd0);
    check("t5_vcnt",  o0_vcnt,  32'd0);
    check("t5_ecnt",  o0_ecnt,  32'd0);
    check("t5_fev",   o0_fev,   32'd0);
    check("t5_fidx",  o0_fidx,  32'd0);
    tick();
    check("t5_idle_busy", o0_busy, 32'd0);
    rst_n = 1'b1;
    tick();
    start0(16'd1);
    send0(1'b1, 1'b0);
    check("t5_re_done", o0_done, 32'd1);
    check("t5_re_pass", o0_pass, 32'd1);
    check("t5_re_vcnt", o0_vcnt, 32'd1);

    // ---- 3: AND2, valid on every other cycle
    s1_start = 1'b1; s1_num = 16'd4; tick(); s1_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s1_valid = 1'b1; s1_a = 2'(i); s1_y = (i == 3); tick();
      s1_valid = 1'b0; tick();
      if (i < 3) check("t3_gap_vcnt", o1_vcnt, 32'(i + 1));
    end
    check("t3_done", o1_done, 32'd1);
    check("t3_vcnt", o1_vcnt, 32'd4);
    check("t3_pass", o1_pass, 32'd1);

    // ---- 3b: AND2 with a wrong response at a=2
    s1_start = 1'b1; s1_num = 16'd4; tick(); s1_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s1_valid = 1'b1; s1_a = 2'(i); s1_y = (i >= 2); tick();
    end
    s1_valid = 1'b0;
    check("t3b_ecnt", o1_ecnt, 32'd1);
    check("t3b_fidx", o1_fidx, 32'd2);
    check("t3b_fa",   o1_fa,   32'd2);
    check("t3b_pass", o1_pass, 32'd0);

    // ---- 6: 2-bit counters, all pairs wrong, two runs
    for (int r = 0; r < 2; r++) begin
      s2_start = 1'b1; s2_num = 2'd3; tick(); s2_start = 1'b0;
      send2(1'b0, 1'b0);
      send2(1'b1, 1'b1);
      send2(1'b0, 1'b0);
      check("t6_done", o2_done, 32'd1);
      check("t6_ecnt", o2_ecnt, 32'd3);
      check("t6_vcnt", o2_vcnt, 32'd3);
      check("t6_fidx", o2_fidx, 32'd0);
      check("t6_pass", o2_pass, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
